// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-ported data memory between the CPU data port and the debug/loader port.
// Latency : grant and memory strobes are combinational; read data and rvalid return one cycle after the grant.
// Backpres: CPU stalls on c_ready=0 (debug win, drain or halt); debug waits on d_gnt=0; a bounded starve counter keeps debug from waiting forever.
//
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-low reset
//   c_*              - CPU request (req/we/addr/wdata), accept (c_ready), read return (c_rdata/c_rvalid)
//   d_*              - debug request (req/we/addr/wdata), accept (d_gnt), read return (d_rdata/d_rvalid)
//   halt_req/ack     - debug exclusive-access handshake
//   m_*              - synchronous single-ported memory (read data one cycle after address)
module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 64,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic [1:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    output logic [DW-1:0] c_rdata,
    output logic          c_rvalid,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    input  logic          halt_req,
    output logic          halt_ack,
    output logic [AW-1:0] m_addr,
    output logic [1:0]    m_we,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       owner_q, owner_d;        // 0 = CPU, 1 = debug: who the returning read belongs to
    logic       c_rvalid_q, c_rvalid_d;
    logic       d_rvalid_q, d_rvalid_d;

    logic       cpu_win;
    logic       dbg_win;

    // Winner selection. Gating with reset keeps the memory and both
    // requesters quiet while reset is held, even mid-cycle.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (reset) begin
            case (state_q)
                NORMAL: begin
                    cpu_win = c_req && !(d_req && (starve_cnt_q == STARVE_LIM));
                    dbg_win = d_req && !cpu_win;
                end
                DRAIN, HALTED: begin
                    dbg_win = d_req;
                end
                default: begin
                    cpu_win = 1'b0;
                    dbg_win = 1'b0;
                end
            endcase
        end
    end

    // Memory port mux; idle drives zeros so an unused cycle is a clean no-op.
    always_comb begin
        m_addr  = '0;
        m_we    = 2'b00;
        m_wdata = '0;
        if (cpu_win) begin
            m_addr  = c_addr;
            m_we    = c_we;
            m_wdata = c_wdata;
        end else if (dbg_win) begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
        end
    end

    // FSM next state, starvation count and read-return bookkeeping.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (halt_req) state_d = DRAIN;
            // One cycle in DRAIN lets a CPU read granted just before the
            // halt return its data before debug owns the memory.
            DRAIN:   state_d = halt_req ? HALTED : NORMAL;
            HALTED:  if (!halt_req) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase

        starve_cnt_d = starve_cnt_q;
        if ((state_q == HALTED) || dbg_win || !d_req) begin
            starve_cnt_d = 4'd0;
        end else if (cpu_win && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        owner_d = owner_q;
        if (dbg_win) begin
            owner_d = 1'b1;
        end else if (cpu_win) begin
            owner_d = 1'b0;
        end

        c_rvalid_d = cpu_win && (c_we == 2'b00);
        d_rvalid_d = dbg_win && (d_we == 2'b00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= 4'd0;
            owner_q      <= 1'b0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
        end
    end

    assign c_ready  = cpu_win;
    assign d_gnt    = dbg_win;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = owner_q ? '0 : m_rdata;
    assign d_rdata  = owner_q ? m_rdata : '0;
    assign halt_ack = (state_q == HALTED);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 64-bit data memory between the CPU data port and a debug/loader port (memory inspection, program load, checker readback).
- Sits between the core's dataadr/writedata/memwrite/readdata interface and the data-memory instance inside top.
- CPU has priority, bounded by a starvation counter.
- A halt handshake gives debug exclusive access while the CPU is stalled.

Parameters:
- AW, 8, word-address width of the data memory.
- DW, 64, data width.
- STARVE, 4, consecutive CPU grants tolerated while d_req is pending; valid range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU access request.
- c_we  in  2  CPU write strobe (memwrite encoding); 00 = read.
- c_addr  in  AW  CPU word address.
- c_wdata  in  DW  CPU write data.
- c_ready  out  1  CPU access accepted this cycle; CPU stalls while c_req=1 and c_ready=0.
- c_rdata  out  DW  CPU read data.
- c_rvalid  out  1  c_rdata valid.
- d_req  in  1  debug request.
- d_we  in  2  debug write strobe.
- d_addr  in  AW  debug address.
- d_wdata  in  DW  debug write data.
- d_gnt  out  1  debug access accepted this cycle.
- d_rdata  out  DW  debug read data.
- d_rvalid  out  1  d_rdata valid.
- halt_req  in  1  debug requests exclusive access.
- halt_ack  out  1  exclusive access held.
- m_addr  out  AW  memory address.
- m_we  out  2  memory write strobe.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; synchronous, valid one cycle after address.

Behaviour:
- One access per cycle.
- Grant is combinational from requests, FSM state and the registered starvation count.
- m_addr, m_we, m_wdata are muxed from the winner. With no winner: m_we=00, m_addr=0, m_wdata=0.
- FSM states: NORMAL, DRAIN, HALTED. Reset state is NORMAL.
- NORMAL arbitration:
  - CPU wins if c_req=1, unless d_req=1 and starve_cnt==STARVE; then debug wins.
  - Debug wins if c_req=0 and d_req=1.
- starve_cnt (4-bit):
  - +1 on each cycle the CPU is granted while d_req=1.
  - Cleared on a debug grant, or when d_req=0.
  - Saturates at STARVE.
- Read return: a granted read (we=00) sets the owner's rvalid exactly 1 cycle later. rdata passes through m_rdata, selected by a registered owner bit. The non-owner's rdata is held at 0.
- Writes produce no rvalid.
- NORMAL -> DRAIN: when halt_req=1. In DRAIN, c_ready=0 and debug may still be granted.
- DRAIN -> HALTED: after one cycle, so any CPU read in flight has returned its rvalid.
- HALTED:
  - halt_ack=1, c_ready=0 always.
  - d_gnt=d_req.
  - starve_cnt held at 0.
- halt_req deasserted in DRAIN or HALTED -> NORMAL next cycle; halt_ack drops the same edge.
- Simultaneous c_req and d_req with starve_cnt<STARVE: CPU wins and d_gnt=0.
- Reset low, at any time including mid-access:
  - Immediately forces state NORMAL, starve_cnt=0, owner=CPU.
  - c_rvalid=0, d_rvalid=0, halt_ack=0.
  - Outputs c_ready, d_gnt and m_we go to 0 while reset is low.
  - A read in flight is dropped with no rvalid.
- Address and data are not checked; wrap-around is the memory's responsibility.

Test Plan:
- CPU only: c_req=1, c_we=01, c_addr=84, c_wdata=7 -> same cycle c_ready=1, m_we=01, m_addr=84, m_wdata=7. Next cycle a read of 84 -> c_rvalid=1 one cycle later with c_rdata=7.
- Debug only: d_req=1, read addr 80 after a CPU write of 1 -> d_gnt=1, then d_rvalid=1 and d_rdata=1 one cycle later; c_rvalid stays 0.
- Contention, STARVE=4: c_req and d_req held high -> CPU granted 4 cycles, debug granted on the 5th, CPU on the 6th; starve_cnt pattern 1,2,3,4,0.
- Halt: CPU read in flight when halt_req rises -> c_rvalid still delivered. DRAIN lasts 1 cycle with c_ready=0. halt_ack=1 from the 2nd cycle. Debug writes addr 128 = 7 while c_req=1 and c_ready stays 0. Drop halt_req -> NORMAL next cycle and CPU granted.
- Async reset mid-read: assert reset low between grant and return -> c_rvalid=0 with no clock edge, all outputs at reset values. Release -> NORMAL, first request granted normally.
- Idle: no requests -> m_we=00, c_ready=0, d_gnt=0, rvalids 0 for 100 cycles.
